// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: walks an external step/compare counter through a table of segments.
// Define CNT_SEQ_WDOG_EN to add a per-pass watchdog that aborts a stuck RUN.
module counter_seq_ctrl #(
  parameter int WIDTH  = 10,
  parameter int SEG_AW = 2,
  parameter int REP_W  = 8,
  parameter int WDOG_W = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              cfg_wr,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_clear_value,
  input  logic [WIDTH-1:0]  cfg_step,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic [SEG_AW-1:0] cfg_last_seg,
  input  logic              cfg_loop,
  input  logic [WDOG_W-1:0] wdog_limit,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  cnt_count_value,
  output logic              cnt_clken,
  output logic              cnt_clear,
  output logic [WIDTH-1:0]  cnt_clear_value,
  output logic [WIDTH-1:0]  cnt_step,
  output logic              cnt_cnt_type,
  output logic              cnt_enable_compare,
  output logic [WIDTH-1:0]  cnt_limit,
  output logic              busy,
  output logic [SEG_AW-1:0] seg_idx,
  output logic              seg_tick,
  output logic              done,
  output logic              cfg_err,
  output logic              wdog_timeout
);
  localparam int NSEG = 2**SEG_AW;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  state_e            state_q, state_d;
  logic [SEG_AW-1:0] seg_idx_q, seg_idx_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [WIDTH-1:0]  clr_q [NSEG];
  logic [WIDTH-1:0]  step_q [NSEG];
  logic [WIDTH-1:0]  lim_q [NSEG];
  logic [REP_W-1:0]  rep_q [NSEG];
  logic              cfg_err_q;
  logic              match, wdog_hit;

  assign cnt_clear_value    = clr_q[seg_idx_q];
  assign cnt_step           = step_q[seg_idx_q];
  assign cnt_limit          = lim_q[seg_idx_q];
  assign cnt_cnt_type       = 1'b0;
  assign busy               = state_q != IDLE;
  assign seg_idx            = seg_idx_q;
  assign cfg_err            = cfg_err_q;
  assign cnt_enable_compare = state_q == RUN;
  assign cnt_clken          = (state_q == LOAD || state_q == RUN) && !stop;
  assign cnt_clear          = state_q == LOAD && !stop;
  assign match              = state_q == RUN && cnt_count_value == cnt_limit;
  assign seg_tick           = match && !stop;
  assign done               = state_q == DONE && !stop;
  assign wdog_timeout       = wdog_hit && !stop;

`ifdef CNT_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  // Cleared outside RUN so it starts from zero on every RUN entry
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) wdog_q <= '0;
    else wdog_q <= (state_q != RUN || match) ? '0 : wdog_q + 1'b1;
  assign wdog_hit = state_q == RUN && !match && wdog_limit != '0 && wdog_q == wdog_limit;
`else
  logic unused_wdog;
  assign unused_wdog = ^wdog_limit;
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d   = LOAD;
        seg_idx_d = '0;
        rep_cnt_d = '0;
      end
      LOAD: state_d = RUN;
      RUN: if (wdog_hit) state_d = IDLE;
        else if (match) begin
          if (rep_cnt_q < rep_q[seg_idx_q]) rep_cnt_d = rep_cnt_q + 1'b1;
          else begin
            rep_cnt_d = '0;
            if (seg_idx_q < cfg_last_seg) begin
              seg_idx_d = seg_idx_q + 1'b1;
              state_d   = LOAD;
            end else if (cfg_loop) begin
              seg_idx_d = '0;
              state_d   = LOAD;
            end else state_d = DONE;
          end
        end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d   = IDLE;
      seg_idx_d = seg_idx_q;
      rep_cnt_d = rep_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      state_q   <= IDLE;
      seg_idx_q <= '0;
      rep_cnt_q <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NSEG; i++) begin
        clr_q[i]  <= '0;
        step_q[i] <= '0;
        lim_q[i]  <= '0;
        rep_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      rep_cnt_q <= rep_cnt_d;
      cfg_err_q <= cfg_wr && busy;
      if (cfg_wr && state_q == IDLE) begin
        clr_q[cfg_addr]  <= cfg_clear_value;
        step_q[cfg_addr] <= cfg_step;
        lim_q[cfg_addr]  <= cfg_limit;
        rep_q[cfg_addr]  <= cfg_repeat;
      end
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed bench driving counter_seq_ctrl against a behavioural step/compare counter.
module tb_counter_seq_ctrl;
  logic        clk = 1'b0, areset_n = 1'b0;
  logic        cfg_wr = 1'b0, cfg_loop = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0]  cfg_addr = '0, cfg_last_seg = '0;
  logic [9:0]  cfg_clear_value = '0, cfg_step = '0, cfg_limit = '0;
  logic [7:0]  cfg_repeat = '0;
  logic [15:0] wdog_limit = '0;
  logic [9:0]  cnt, cnt_clear_value, cnt_step, cnt_limit;
  logic        cnt_clken, cnt_clear, cnt_cnt_type, cnt_enable_compare;
  logic        busy, seg_tick, done, cfg_err, wdog_timeout;
  logic [1:0]  seg_idx;
  logic [4:0]  obs;
  logic [7:0]  all_flags;
  int          checks = 0, failures = 0;

  counter_seq_ctrl dut (
    .clk(clk), .areset_n(areset_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_clear_value(cfg_clear_value), .cfg_step(cfg_step), .cfg_limit(cfg_limit),
    .cfg_repeat(cfg_repeat), .cfg_last_seg(cfg_last_seg), .cfg_loop(cfg_loop),
    .wdog_limit(wdog_limit), .start(start), .stop(stop), .cnt_count_value(cnt),
    .cnt_clken(cnt_clken), .cnt_clear(cnt_clear), .cnt_clear_value(cnt_clear_value),
    .cnt_step(cnt_step), .cnt_cnt_type(cnt_cnt_type), .cnt_enable_compare(cnt_enable_compare),
    .cnt_limit(cnt_limit), .busy(busy), .seg_idx(seg_idx), .seg_tick(seg_tick),
    .done(done), .cfg_err(cfg_err), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  // Attached counter: clear or compare-match reloads clear_value, otherwise adds step
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) cnt <= '0;
    else if (cnt_clken)
      cnt <= (cnt_clear || (cnt_enable_compare && cnt == cnt_limit)) ? cnt_clear_value : cnt + cnt_step;

  assign obs       = {busy, cnt_clken, cnt_clear, seg_tick, done};
  assign all_flags = {busy, cnt_clken, cnt_clear, cnt_enable_compare, seg_tick, done, cfg_err, wdog_timeout};

  task automatic wr_seg(input logic [1:0] a, input logic [9:0] c, input logic [9:0] s,
                        input logic [9:0] l, input logic [7:0] r);
    cfg_wr = 1'b1; cfg_addr = a; cfg_clear_value = c; cfg_step = s; cfg_limit = l; cfg_repeat = r;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (all_flags !== 8'h00) begin failures++; $display("FAIL reset_flags: got %b expected 00000000", all_flags); end
    checks++;
    if ({cnt_clear_value, cnt_step, cnt_limit, seg_idx, cnt_cnt_type} !== '0) begin
      failures++; $display("FAIL reset_table: got %h/%h/%h idx %0d type %b expected all zero",
                           cnt_clear_value, cnt_step, cnt_limit, seg_idx, cnt_cnt_type);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_stop_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [4:0] ef [11] = '{5'b11100, 5'b11000, 5'b11000, 5'b11000, 5'b11010, 5'b11000,
                            5'b11000, 5'b11000, 5'b11010, 5'b10001, 5'b00000};
    int ec [11] = '{-1, 0, 1, 2, 3, 0, 1, 2, 3, -1, -1};
    wr_seg(2'd0, 10'd0, 10'd1, 10'd3, 8'd1);
    cfg_last_seg = 2'd0; cfg_loop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (obs !== ef[c]) begin failures++; $display("FAIL basic_flags c%0d: got %b expected %b", c, obs, ef[c]); end
      if (ec[c] >= 0) begin
        checks++;
        if (cnt !== 10'(ec[c])) begin failures++; $display("FAIL basic_count c%0d: got %0d expected %0d", c, cnt, ec[c]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_two_seg();
    logic [4:0] ef [10] = '{5'b11100, 5'b11000, 5'b11000, 5'b11010, 5'b11100,
                            5'b11000, 5'b11000, 5'b11010, 5'b10001, 5'b00000};
    int ec [10] = '{-1, 5, 7, 9, -1, 20, 19, 18, -1, -1};
    int ei [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    wr_seg(2'd0, 10'd5, 10'd2, 10'd9, 8'd0);
    wr_seg(2'd1, 10'd20, 10'h3FF, 10'd18, 8'd0);
    cfg_last_seg = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs !== ef[c] || seg_idx !== 2'(ei[c])) begin
        failures++; $display("FAIL two_seg c%0d: flags %b idx %0d expected %b idx %0d", c, obs, seg_idx, ef[c], ei[c]);
      end
      if (ec[c] >= 0) begin
        checks++;
        if (cnt !== 10'(ec[c])) begin failures++; $display("FAIL two_seg_count c%0d: got %0d expected %0d", c, cnt, ec[c]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt !== 10'd7) begin failures++; $display("FAIL abort_pre: count got %0d expected 7", cnt); end
    stop = 1'b1;
    #1;
    checks++;
    if (cnt_clken !== 1'b0 || seg_tick !== 1'b0) begin
      failures++; $display("FAIL abort_cycle: clken %b tick %b expected 0 0", cnt_clken, seg_tick);
    end
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({busy, cnt_clken, seg_tick, done} !== 4'b0000) begin
        failures++; $display("FAIL abort_idle c%0d: busy/clken/tick/done got %b expected 0000", c, {busy, cnt_clken, seg_tick, done});
      end
      @(negedge clk);
    end
    checks++;
    if (cnt !== 10'd7) begin failures++; $display("FAIL abort_hold: count got %0d expected 7", cnt); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (seg_idx !== 2'd0 || cnt_clear !== 1'b1) begin
      failures++; $display("FAIL restart_load: idx %0d clear %b expected 0 1", seg_idx, cnt_clear);
    end
    @(negedge clk);
    checks++;
    if (cnt !== 10'd5) begin failures++; $display("FAIL restart_count: got %0d expected 5", cnt); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_loop_protect();
    wr_seg(2'd0, 10'd0, 10'd1, 10'd1, 8'd0);
    cfg_last_seg = 2'd0; cfg_loop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      checks++;
      if (seg_tick !== (c % 3 == 2) || busy !== 1'b1) begin
        failures++; $display("FAIL loop c%0d: tick %b busy %b expected %b 1", c, seg_tick, busy, c % 3 == 2);
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (cfg_err !== (c == 5) || cnt_clear_value !== 10'd0 || cnt_limit !== 10'd1) begin
          failures++; $display("FAIL cfg_protect c%0d: err %b clr %0d lim %0d expected %b 0 1", c, cfg_err, cnt_clear_value, cnt_limit, c == 5);
        end
      end
      cfg_wr = (c == 4);
      cfg_clear_value = 10'd7; cfg_limit = 10'd9;
      start = (c == 8);
      @(negedge clk);
    end
    cfg_wr = 1'b0; start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL loop_stop: busy %b done %b expected 0 0", busy, done); end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    areset_n = 1'b0;
    #1;
    checks++;
    if (all_flags !== 8'h00 || cnt_limit !== 10'd0 || seg_idx !== 2'd0) begin
      failures++; $display("FAIL async_reset: flags %b lim %0d idx %0d expected 0 0 0", all_flags, cnt_limit, seg_idx);
    end
    @(negedge clk);
    areset_n = 1'b1;
    cfg_loop = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cnt_clken !== 1'b0) begin
        failures++; $display("FAIL post_reset c%0d: busy %b clken %b expected 0 0", c, busy, cnt_clken);
      end
    end
  endtask

`ifdef CNT_SEQ_WDOG_EN
  task automatic test_wdog();
    wr_seg(2'd0, 10'd0, 10'd2, 10'd3, 8'd0);
    cfg_last_seg = 2'd0; cfg_loop = 1'b0; wdog_limit = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (wdog_timeout !== (c == 11) || busy !== 1'b1) begin
        failures++; $display("FAIL wdog c%0d: timeout %b busy %b expected %b 1", c, wdog_timeout, busy, c == 11);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL wdog_idle: busy %b done %b expected 0 0", busy, done); end
    wdog_limit = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (wdog_timeout !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL wdog_off c%0d: timeout %b busy %b expected 0 1", c, wdog_timeout, busy);
      end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_two_seg();
    test_abort();
    test_loop_protect();
    test_async_reset();
`ifdef CNT_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
